// File: rtl/gelato_ifetch_pkg.sv
// Shared types and sizing for the gelato instruction-fetch stage.
package gelato_types;

    localparam int ADDR_WIDTH         = 32;
    localparam int INST_WIDTH         = 32;
    localparam int ICACHE_LINE_WORDS  = 4;
    localparam int WARP_NUM_WIDTH     = 5;
    localparam int SPLIT_TABLE_WIDTH  = 3;

    typedef logic [ADDR_WIDTH-1:0]        addr_t;
    typedef logic [INST_WIDTH-1:0]        inst_t;
    typedef logic [WARP_NUM_WIDTH-1:0]    warp_num_t;
    typedef logic [SPLIT_TABLE_WIDTH-1:0] split_table_num_t;

    typedef enum logic [1:0] {
        IFETCH_IDLE = 2'd0,
        IFETCH_REQ  = 2'd1,
        IFETCH_WAIT = 2'd2,
        IFETCH_OUT  = 2'd3
    } ifetch_state_e;

endpackage

// File: rtl/gelato_ifetch_line_buf.sv
// Single-entry I-cache line buffer: tag, valid and data of the most recently
// returned line. Only instantiated when GELATO_IFETCH_LINE_BUF_EN is defined.
module gelato_ifetch_line_buf #(
    parameter int TAG_W  = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [LINE_W-1:0] rd_data,
    input  logic              refill_en,
    input  logic [TAG_W-1:0]  refill_tag,
    input  logic [LINE_W-1:0] refill_data
);

    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] data_q;

    // Refill on every returned line; reset invalidates the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (refill_en) begin
            valid_q <= 1'b1;
            tag_q   <= refill_tag;
            data_q  <= refill_data;
        end
    end

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign rd_data = data_q;

endmodule

// File: rtl/gelato_ifetch.sv
// Instruction-fetch stage: accepts one scheduler request, fetches its I-cache
// line, extracts the addressed word and holds it for decode under valid/ready.
// Optional feature macro: GELATO_IFETCH_LINE_BUF_EN (last-line buffer, hits
// skip the I-cache request and go straight to OUT).
//
// state | meaning
// IDLE  | waiting for a scheduler request
// REQ   | line request presented to the I-cache
// WAIT  | request accepted, waiting for the line
// OUT   | instruction held for decode
module gelato_ifetch
    import gelato_types::*;
#(
    parameter int ADDR_W     = ADDR_WIDTH,
    parameter int INST_W     = INST_WIDTH,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_valid,
    input  logic [ADDR_W-1:0]            fetch_pc,
    input  warp_num_t                    fetch_warp_num,
    input  split_table_num_t             fetch_split_table_num,
    output logic                         fetch_caught,
    output logic                         icache_req_valid,
    output logic [ADDR_W-1:0]            icache_req_addr,
    input  logic                         icache_req_ready,
    input  logic                         icache_rsp_valid,
    input  logic [LINE_WORDS*INST_W-1:0] icache_rsp_data,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [INST_W-1:0]            inst,
    output logic [ADDR_W-1:0]            inst_pc,
    output warp_num_t                    inst_warp_num,
    output split_table_num_t             inst_split_table_num,
    output logic                         busy
);

    localparam int LINE_W = LINE_WORDS * INST_W;
    localparam int BYTE_W = $clog2(INST_W / 8);
    localparam int SEL_W  = $clog2(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    localparam logic [1:0] S_IDLE = IFETCH_IDLE;
    localparam logic [1:0] S_REQ  = IFETCH_REQ;
    localparam logic [1:0] S_WAIT = IFETCH_WAIT;
    localparam logic [1:0] S_OUT  = IFETCH_OUT;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    warp_num_t         warp_q, warp_d;
    split_table_num_t  split_q, split_d;
    logic [INST_W-1:0] inst_q, inst_d;

    logic [INST_W-1:0] rsp_words [LINE_WORDS];
    logic [SEL_W-1:0]  rsp_sel;
    logic              buf_hit;
    logic [INST_W-1:0] buf_word;

    assign fetch_caught     = (state_q == S_IDLE) && fetch_valid && !rst;
    assign icache_req_valid = (state_q == S_REQ);
    assign icache_req_addr  = icache_req_valid ? {pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign inst_valid       = (state_q == S_OUT);
    assign busy             = (state_q != S_IDLE);
    assign inst             = inst_q;
    assign inst_pc          = pc_q;
    assign inst_warp_num    = warp_q;
    assign inst_split_table_num = split_q;

    // PC bits below instruction alignment are dropped; the next bits pick the word.
    assign rsp_sel = pc_q[BYTE_W +: SEL_W];

    // Split the returned line into words, word 0 in the LSBs.
    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            rsp_words[i] = icache_rsp_data[i*INST_W +: INST_W];
        end
    end

`ifdef GELATO_IFETCH_LINE_BUF_EN
    logic [LINE_W-1:0] buf_data;
    logic [INST_W-1:0] buf_words [LINE_WORDS];
    logic [SEL_W-1:0]  buf_sel;

    // Lookup uses the incoming request so a hit can go straight to OUT.
    gelato_ifetch_line_buf #(
        .TAG_W  (ADDR_W - OFF_W),
        .LINE_W (LINE_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .lookup_tag  (fetch_pc[ADDR_W-1:OFF_W]),
        .hit         (buf_hit),
        .rd_data     (buf_data),
        .refill_en   ((state_q == S_WAIT) && icache_rsp_valid),
        .refill_tag  (pc_q[ADDR_W-1:OFF_W]),
        .refill_data (icache_rsp_data)
    );

    assign buf_sel = fetch_pc[BYTE_W +: SEL_W];

    // Split the buffered line into words for the hit path.
    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            buf_words[i] = buf_data[i*INST_W +: INST_W];
        end
    end

    assign buf_word = buf_words[buf_sel];
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    // Next-state: FSM sequencing, request latch and instruction capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        warp_d  = warp_q;
        split_d = split_q;
        inst_d  = inst_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_caught) begin
                    pc_d    = fetch_pc;
                    warp_d  = fetch_warp_num;
                    split_d = fetch_split_table_num;
                    if (buf_hit) begin
                        inst_d  = buf_word;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (icache_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (icache_rsp_valid) begin
                    inst_d  = rsp_words[rsp_sel];
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            warp_q  <= '0;
            split_q <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            warp_q  <= warp_d;
            split_q <= split_d;
            inst_q  <= inst_d;
        end
    end

endmodule

// File: tb/tb_gelato_ifetch.sv
// Self-checking bench for gelato_ifetch: table vectors, hand-written corner
// sequences and randomized requests against a behavioural fetch model.
module tb_gelato_ifetch;
    import gelato_types::*;

    localparam int LW = ICACHE_LINE_WORDS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                fetch_valid = 1'b0;
    logic [31:0]         fetch_pc = '0;
    warp_num_t           fetch_warp_num = '0;
    split_table_num_t    fetch_split_table_num = '0;
    logic                fetch_caught;
    logic                icache_req_valid;
    logic [31:0]         icache_req_addr;
    logic                icache_req_ready = 1'b0;
    logic                icache_rsp_valid = 1'b0;
    logic [LW*32-1:0]    icache_rsp_data = '0;
    logic                inst_valid;
    logic                inst_ready = 1'b0;
    logic [31:0]         inst;
    logic [31:0]         inst_pc;
    warp_num_t           inst_warp_num;
    split_table_num_t    inst_split_table_num;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit          lb_valid = 1'b0;
    logic [31:0] lb_line  = '0;

    typedef struct {
        logic [31:0]      pc;
        warp_num_t        warp;
        split_table_num_t split;
        int               rdy;
        int               rsp;
        int               outd;
        logic [31:0]      exp_inst;
        logic [31:0]      exp_line;
    } vec_t;

    vec_t table_v [7];

    gelato_ifetch dut (
        .clk                   (clk),
        .rst                   (rst),
        .fetch_valid           (fetch_valid),
        .fetch_pc              (fetch_pc),
        .fetch_warp_num        (fetch_warp_num),
        .fetch_split_table_num (fetch_split_table_num),
        .fetch_caught          (fetch_caught),
        .icache_req_valid      (icache_req_valid),
        .icache_req_addr       (icache_req_addr),
        .icache_req_ready      (icache_req_ready),
        .icache_rsp_valid      (icache_rsp_valid),
        .icache_rsp_data       (icache_rsp_data),
        .inst_valid            (inst_valid),
        .inst_ready            (inst_ready),
        .inst                  (inst),
        .inst_pc               (inst_pc),
        .inst_warp_num         (inst_warp_num),
        .inst_split_table_num  (inst_split_table_num),
        .busy                  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    // Memory contents seen by the bench's I-cache; word 2 of line 0x1000 is fixed.
    function automatic logic [31:0] mem_word(input logic [31:0] line, input int idx);
        if (line == 32'h1000 && idx == 2) return 32'hDEADBEEF;
        return (line * 32'h9E3779B1) ^ (32'(idx) * 32'h01010101) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [LW*32-1:0] mem_line(input logic [31:0] line);
        logic [LW*32-1:0] d;
        d = '0;
        for (int i = 0; i < LW; i++) d[i*32 +: 32] = mem_word(line, i);
        return d;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] pc);
        return pc - (pc % 32'(LW * 4));
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] pc);
        return mem_word(line_of(pc), int'((pc / 4) % 32'(LW)));
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input int w, input int s,
                                input int rdy, input int rsp, input int outd);
        vec_t v;
        v.pc = pc; v.warp = warp_num_t'(w); v.split = split_table_num_t'(s);
        v.rdy = rdy; v.rsp = rsp; v.outd = outd;
        v.exp_inst = model_inst(pc);
        v.exp_line = line_of(pc);
        return v;
    endfunction

    task automatic model_refill(input logic [31:0] line);
`ifdef GELATO_IFETCH_LINE_BUF_EN
        lb_valid = 1'b1;
        lb_line  = line;
`endif
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One complete fetch with chosen I-cache and decode stalls.
    task automatic do_fetch(input vec_t v, input bit stray);
        bit hit;
        int t0;
        hit = lb_valid && (lb_line == v.exp_line);
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_pc = v.pc;
        fetch_warp_num = v.warp;
        fetch_split_table_num = v.split;
        #1 chk("caught", fetch_caught, 1);
        t0 = cyc;
        @(negedge clk);
        #1 chk("caught_once", fetch_caught, 0);
        fetch_valid = 1'b0;
        if (hit) begin
            chk("hit_no_req", icache_req_valid, 0);
        end else begin
            for (int i = 0; i < v.rdy; i++) begin
                fetch_valid = 1'b1;
                fetch_pc = v.pc + 32'h40;
                icache_rsp_valid = stray;
                icache_rsp_data = {LW{32'hBAD0BAD0}};
                #1;
                chk("stall_req_valid", icache_req_valid, 1);
                chk("stall_req_addr", icache_req_addr, v.exp_line);
                chk("stall_no_caught", fetch_caught, 0);
                @(negedge clk);
            end
            fetch_valid = 1'b0;
            icache_rsp_valid = 1'b0;
            chk("req_valid", icache_req_valid, 1);
            chk("req_addr", icache_req_addr, v.exp_line);
            chk("req_no_inst", inst_valid, 0);
            icache_req_ready = 1'b1;
            @(negedge clk);
            icache_req_ready = 1'b0;
            for (int i = 0; i < v.rsp; i++) begin
                chk("wait_req_low", icache_req_valid, 0);
                chk("wait_no_inst", inst_valid, 0);
                @(negedge clk);
            end
            icache_rsp_valid = 1'b1;
            icache_rsp_data = mem_line(v.exp_line);
            @(negedge clk);
            icache_rsp_valid = 1'b0;
            icache_rsp_data = {LW{32'h0F0F1234}};
            model_refill(v.exp_line);
        end
        chk("latency", 64'(cyc - t0), hit ? 64'd1 : 64'(3 + v.rdy + v.rsp));
        chk("inst_valid", inst_valid, 1);
        chk("inst", inst, v.exp_inst);
        chk("inst_pc", inst_pc, v.pc);
        chk("inst_warp", inst_warp_num, v.warp);
        chk("inst_split", inst_split_table_num, v.split);
        for (int i = 0; i < v.outd; i++) begin
            inst_ready = 1'b0;
            fetch_valid = 1'b1;
            fetch_pc = v.pc + 32'h80;
            #1 chk("out_no_caught", fetch_caught, 0);
            @(negedge clk);
            chk("out_hold_valid", inst_valid, 1);
            chk("out_hold_inst", inst, v.exp_inst);
            chk("out_hold_pc", inst_pc, v.pc);
        end
        fetch_valid = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("done_inst_valid", inst_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        int caught_n, out_n, hs_cyc, prev_req;
        bit adv;
        logic [31:0] inflight;
        logic [31:0] b2b_pc [2];
        vec_t rv;
        logic [31:0] rlines [4];

        table_v[0] = mk(32'h1008, 3, 1, 0, 0, 0);
        table_v[1] = mk(32'h1010, 1, 0, 5, 2, 4);
        table_v[2] = mk(32'h100B, 7, 2, 0, 1, 0);
        table_v[3] = mk(32'h2000, 2, 5, 0, 0, 0);
        table_v[4] = mk(32'h2004, 2, 5, 0, 0, 1);
        table_v[5] = mk(32'h2010, 4, 6, 1, 0, 0);
        table_v[6] = mk(32'h201C, 0, 7, 0, 3, 2);

        // Reset state, with a request offered during reset.
        fetch_valid = 1'b1;
        fetch_pc = 32'h1234;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_caught", fetch_caught, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_req_valid", icache_req_valid, 0);
        chk("rst_req_addr", icache_req_addr, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        fetch_valid = 1'b0;
        rst = 1'b0;

        // Table vectors.
        for (int i = 0; i < 7; i++) do_fetch(table_v[i], i[0]);

        // Reset mid-WAIT, then a late response must be dropped.
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_pc = 32'h4000;
        @(negedge clk);
        fetch_valid = 1'b0;
        icache_req_ready = 1'b1;
        @(negedge clk);
        icache_req_ready = 1'b0;
        chk("wait_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lb_valid = 1'b0;
        chk("rstw_busy", busy, 0);
        chk("rstw_inst_valid", inst_valid, 0);
        chk("rstw_req_valid", icache_req_valid, 0);
        icache_rsp_valid = 1'b1;
        icache_rsp_data = mem_line(32'h4000);
        @(negedge clk);
        icache_rsp_valid = 1'b0;
        chk("late_rsp_inst_valid", inst_valid, 0);
        chk("late_rsp_busy", busy, 0);
        do_fetch(mk(32'h4004, 9, 3, 0, 0, 0), 1'b0);

        // Stray response in IDLE, then the misaligned fetch again.
        icache_rsp_valid = 1'b1;
        icache_rsp_data = {LW{32'hFFFF0000}};
        @(negedge clk);
        icache_rsp_valid = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_inst_valid", inst_valid, 0);
        chk("stray_req_valid", icache_req_valid, 0);
        do_fetch(mk(32'h100B, 6, 4, 1, 1, 1), 1'b1);

        // Back-to-back: fetch_valid held high across two requests.
        b2b_pc[0] = 32'h3000;
        b2b_pc[1] = 32'h3104;
        caught_n = 0; out_n = 0; hs_cyc = -100; prev_req = 0; adv = 1'b0; inflight = '0;
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_pc = b2b_pc[0];
        inst_ready = 1'b1;
        icache_req_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (adv) begin
                adv = 1'b0;
                if (caught_n == 1) fetch_pc = b2b_pc[1];
                else fetch_valid = 1'b0;
            end
            icache_rsp_valid = prev_req[0];
            icache_rsp_data = mem_line(inflight);
            if (icache_req_valid) inflight = icache_req_addr;
            prev_req = int'(icache_req_valid);
            #1;
            if (fetch_caught) begin
                caught_n++;
                if (caught_n == 2) chk("b2b_gap", 64'(cyc), 64'(hs_cyc + 1));
                adv = 1'b1;
            end
            if (inst_valid) begin
                if (out_n < 2) chk("b2b_inst", inst, model_inst(b2b_pc[out_n]));
                out_n++;
                hs_cyc = cyc;
            end
            @(negedge clk);
        end
        fetch_valid = 1'b0;
        inst_ready = 1'b0;
        icache_req_ready = 1'b0;
        icache_rsp_valid = 1'b0;
        chk("b2b_caught_count", 64'(caught_n), 2);
        chk("b2b_out_count", 64'(out_n), 2);
        model_refill(32'h3100);

        // Randomized requests over a few lines so the buffer sees hits and misses.
        rlines[0] = 32'h5000; rlines[1] = 32'h5010; rlines[2] = 32'h5020; rlines[3] = 32'h6000;
        for (int n = 0; n < 40; n++) begin
            rv = mk(rlines[$urandom_range(0, 3)] + 32'($urandom_range(0, 15)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
            do_fetch(rv, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
